// File: rtl/axil2lb_arb.sv
// AXI4-Lite slave to local-bus bridge: one-entry AW/W/AR buffers, round-robin write/read arbitration, one LB access at a time.
// Latency: address accept to B/R valid is 3 cycles with a zero-wait LB. Backpressure: each AXI ready is low while its buffer is full.
// Optional LB_TIMEOUT_EN: a stalled LB access ends after TIMEOUT_CYCLES cycles and answers SLVERR.
module axil2lb_arb #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   axil_awaddr,
   input  logic [2:0]          axil_awprot,
   input  logic                axil_awvalid,
   output logic                axil_awready,
   input  logic [DATA_W-1:0]   axil_wdata,
   input  logic [DATA_W/8-1:0] axil_wstrb,
   input  logic                axil_wvalid,
   output logic                axil_wready,
   output logic [1:0]          axil_bresp,
   output logic                axil_bvalid,
   input  logic                axil_bready,
   input  logic [ADDR_W-1:0]   axil_araddr,
   input  logic [2:0]          axil_arprot,
   input  logic                axil_arvalid,
   output logic                axil_arready,
   output logic [DATA_W-1:0]   axil_rdata,
   output logic [1:0]          axil_rresp,
   output logic                axil_rvalid,
   input  logic                axil_rready,
   output logic [ADDR_W-1:0]   waddr,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wen,
   input  logic                wready,
   output logic [ADDR_W-1:0]   raddr,
   output logic                ren,
   input  logic [DATA_W-1:0]   rdata,
   input  logic                rvalid
);

   typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t                state, state_nxt;
   logic                  aw_full, w_full, ar_full;
   logic                  prio_rd, live;
   logic [ADDR_W-1:0]     aw_addr, ar_addr;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_strb;
   logic                  grant, wr_end, rd_end, to_hit;
   logic                  unused_prot;

   assign unused_prot = ^{axil_awprot, axil_arprot};

   // live keeps every ready low while reset is asserted
   assign axil_awready = live & ~aw_full;
   assign axil_wready  = live & ~w_full;
   assign axil_arready = live & ~ar_full;

   assign waddr       = aw_addr;
   assign wdata       = w_data;
   assign wstrb       = w_strb;
   assign raddr       = ar_addr;
   assign wen         = (state == WR);
   assign ren         = (state == RD);
   assign axil_bvalid = (state == WRESP);
   assign axil_rvalid = (state == RRESP);

`ifdef LB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] to_cnt;

   assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_cnt <= '0;
      else if (state == IDLE)
         to_cnt <= '0;
      else if (wen || ren)
         to_cnt <= to_cnt + 1'b1;
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (aw_full && w_full && (!ar_full || !prio_rd)) begin
               state_nxt = WR;
               grant     = 1'b1;
            end else if (ar_full) begin
               state_nxt = RD;
               grant     = 1'b1;
            end
         end
         WR:      if (wready || to_hit) state_nxt = WRESP;
         WRESP:   if (axil_bready)      state_nxt = IDLE;
         RD:      if (rvalid || to_hit) state_nxt = RRESP;
         RRESP:   if (axil_rready)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_end = (state == WR) && (state_nxt == WRESP);
   assign rd_end = (state == RD) && (state_nxt == RRESP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         live       <= 1'b0;
         prio_rd    <= 1'b0;
         aw_full    <= 1'b0;
         w_full     <= 1'b0;
         ar_full    <= 1'b0;
         aw_addr    <= '0;
         w_data     <= '0;
         w_strb     <= '0;
         ar_addr    <= '0;
         axil_bresp <= RESP_OKAY;
         axil_rresp <= RESP_OKAY;
         axil_rdata <= '0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
         if (grant)
            prio_rd <= ~prio_rd;

         if (axil_awvalid && axil_awready) begin
            aw_full <= 1'b1;
            aw_addr <= axil_awaddr;
         end else if (wr_end) begin
            aw_full <= 1'b0;
         end

         if (axil_wvalid && axil_wready) begin
            w_full <= 1'b1;
            w_data <= axil_wdata;
            w_strb <= axil_wstrb;
         end else if (wr_end) begin
            w_full <= 1'b0;
         end

         if (axil_arvalid && axil_arready) begin
            ar_full <= 1'b1;
            ar_addr <= axil_araddr;
         end else if (rd_end) begin
            ar_full <= 1'b0;
         end

         // a handshake in the limit cycle wins over the timeout
         if (wr_end)
            axil_bresp <= wready ? RESP_OKAY : RESP_SLVERR;
         if (rd_end) begin
            axil_rresp <= rvalid ? RESP_OKAY : RESP_SLVERR;
            axil_rdata <= rvalid ? rdata : '0;
         end
      end
   end

endmodule

// File: tb/tb_axil2lb_arb.sv
// Scoreboard bench for axil2lb_arb: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_axil2lb_arb;

`ifdef LB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] axil_awaddr = '0, axil_araddr = '0;
   logic [2:0]  axil_awprot = '0, axil_arprot = '0;
   logic        axil_awvalid = 1'b0, axil_wvalid = 1'b0, axil_arvalid = 1'b0;
   logic        axil_bready = 1'b1, axil_rready = 1'b1;
   logic [31:0] axil_wdata = '0;
   logic [3:0]  axil_wstrb = '0;
   logic        axil_awready, axil_wready, axil_arready, axil_bvalid, axil_rvalid;
   logic [1:0]  axil_bresp, axil_rresp;
   logic [31:0] axil_rdata;
   logic [15:0] waddr, raddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wen, ren;
   logic        lb_wready = 1'b0, lb_rvalid = 1'b0;
   logic [31:0] lb_rdata = '0;

   always #5 clk = ~clk;

   axil2lb_arb #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot), .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
      .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
      .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
      .axil_araddr(axil_araddr), .axil_arprot(axil_arprot), .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
      .axil_rdata(axil_rdata), .axil_rresp(axil_rresp), .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
      .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen), .wready(lb_wready),
      .raddr(raddr), .ren(ren), .rdata(lb_rdata), .rvalid(lb_rvalid)
   );

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard queues
   logic [51:0] exp_lbw[$];
   logic [1:0]  exp_b[$];
   logic [33:0] exp_r[$];
   int          exp_g[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
   endtask

   task automatic pop_grant(input int kind);
      if (exp_g.size() == 0) unexpected("grant");
      else chk("grant_order", 64'(kind), 64'(exp_g.pop_front()));
   endtask

   // LB model: answers wen/ren after a programmable number of wait cycles (-1 = never)
   int          wdelay = 0, rdelay = 0, wcnt = 0, rcnt = 0;
   logic [31:0] rdata_val = '0;
   bit          spur = 1'b0;

   initial forever begin
      @(posedge clk);
      #1;
      lb_wready = 1'b0;
      lb_rvalid = 1'b0;
      lb_rdata  = 32'hbad0bad0;
      if (wen) begin
         if (wdelay >= 0 && wcnt >= wdelay) begin lb_wready = 1'b1; wcnt = 0; end
         else wcnt++;
      end else wcnt = 0;
      if (ren) begin
         if (rdelay >= 0 && rcnt >= rdelay) begin lb_rvalid = 1'b1; lb_rdata = rdata_val; rcnt = 0; end
         else rcnt++;
      end else rcnt = 0;
      if (spur) begin lb_wready = 1'b1; lb_rvalid = 1'b1; spur = 1'b0; end
   end

   // monitor
   logic        wen_q = 0, ren_q = 0, rv_q = 0, bv_q = 0, axr_q = 0;
   logic [51:0] prev_w = '0;
   logic [15:0] prev_ra = '0;
   int          wen_cyc = 0, ren_run = 0, ren_len_last = 0;
   int          t_aw = 0, t_ar = 0, lat_w = -1, lat_r = -1;

   always @(negedge clk) begin
      if (rst) begin
         chk("wen_ren_excl", 64'(wen & ren), 64'd0);
         if (wen && !wen_q) pop_grant(1);
         if (ren && !ren_q) pop_grant(2);
         if (wen && wen_q) chk("wen_stable", 64'({waddr, wdata, wstrb}), 64'(prev_w));
         if (ren && ren_q) chk("raddr_stable", 64'(raddr), 64'(prev_ra));
         if (rv_q) chk("ren_after_rvalid", 64'(ren), 64'd0);
         if (wen && lb_wready) begin
            if (exp_lbw.size() == 0) unexpected("lb_write");
            else chk("lb_write", 64'({waddr, wdata, wstrb}), 64'(exp_lbw.pop_front()));
         end
         if (axil_bvalid && axil_bready) begin
            if (exp_b.size() == 0) unexpected("bresp");
            else chk("bresp", 64'(axil_bresp), 64'(exp_b.pop_front()));
         end
         if (axil_rvalid && axil_rready) begin
            if (exp_r.size() == 0) unexpected("rresp");
            else chk("rresp_rdata", 64'({axil_rresp, axil_rdata}), 64'(exp_r.pop_front()));
         end
         if (axil_awvalid && axil_awready) t_aw = cyc;
         if (axil_arvalid && axil_arready) t_ar = cyc;
         if (axil_bvalid && !bv_q) lat_w = cyc - t_aw;
         if (axil_rvalid && !axr_q) lat_r = cyc - t_ar;
         if (wen) wen_cyc++;
         if (ren) ren_run++;
         else if (ren_q) begin ren_len_last = ren_run; ren_run = 0; end
      end
      wen_q   = wen;
      ren_q   = ren;
      rv_q    = ren & lb_rvalid;
      bv_q    = axil_bvalid;
      axr_q   = axil_rvalid;
      prev_w  = {waddr, wdata, wstrb};
      prev_ra = raddr;
   end

   // AXI drivers
   task automatic send_aw(input logic [15:0] a);
      int n = 0;
      axil_awaddr = a; axil_awvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!axil_awready && n < 2000);
      if (!axil_awready) unexpected("aw_accept_timeout");
      @(posedge clk); #1;
      axil_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      axil_wdata = d; axil_wstrb = s; axil_wvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!axil_wready && n < 2000);
      if (!axil_wready) unexpected("w_accept_timeout");
      @(posedge clk); #1;
      axil_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [15:0] a);
      int n = 0;
      axil_araddr = a; axil_arvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!axil_arready && n < 2000);
      if (!axil_arready) unexpected("ar_accept_timeout");
      @(posedge clk); #1;
      axil_arvalid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_g.size() != 0) && n < 3000) begin
         @(negedge clk); n++;
      end
      if (exp_b.size() != 0 || exp_r.size() != 0 || exp_g.size() != 0) unexpected({name, "_response_timeout"});
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_g.push_back(1);
      exp_lbw.push_back({a, d, s});
      exp_b.push_back(2'b00);
   endtask

   task automatic expect_rd(input logic [1:0] resp, input logic [31:0] d);
      exp_g.push_back(2);
      exp_r.push_back({resp, d});
   endtask

   initial begin
      int w0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({axil_awready, axil_wready, axil_arready, axil_bvalid, axil_rvalid, wen, ren,
                                axil_bresp, axil_rresp}), 64'd0);
      chk("reset_data", 64'({waddr, wdata, wstrb}), 64'd0);
      chk("reset_rdata", 64'({raddr, axil_rdata}), 64'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: AW then W three cycles later
      w0 = wen_cyc;
      expect_wr(16'h0004, 32'hdeadbeef, 4'hf);
      send_aw(16'h0004);
      repeat (3) @(posedge clk);
      #1;
      send_w(32'hdeadbeef, 4'hf);
      wait_done("t1");
      chk("t1_wen_cycles", 64'(wen_cyc - w0), 64'd1);

      // 2: W before AW, partial strobes; AW completes the pair
      expect_wr(16'h000c, 32'hcafebabe, 4'b0110);
      send_w(32'hcafebabe, 4'b0110);
      repeat (2) @(posedge clk);
      #1;
      send_aw(16'h000c);
      wait_done("t2");
      chk("t2_write_latency", 64'(lat_w), 64'd3);

      // 3: long LB write stall (hits the limit cycle exactly in the timeout build)
      wdelay = (TO > 16) ? 800 : TO - 1;
      w0 = wen_cyc;
      expect_wr(16'h0010, 32'h0acce55, 4'hf);
      fork
         send_aw(16'h0010);
         send_w(32'h0acce55, 4'hf);
      join
      wait_done("t3");
      chk("t3_wen_cycles", 64'(wen_cyc - w0), 64'(wdelay + 1));
      wdelay = 0;

      // 4: reads with zero and five LB wait cycles
      rdata_val = 32'hc0debabe;
      rdelay = 0;
      expect_rd(2'b00, 32'hc0debabe);
      send_ar(16'h0014);
      wait_done("t4a");
      chk("t4_read_latency", 64'(lat_r), 64'd3);
      rdelay = 5;
      axil_rready = 1'b0;
      expect_rd(2'b00, 32'hc0debabe);
      send_ar(16'h0014);
      begin
         int n = 0;
         while (!axil_rvalid && n < 100) begin @(negedge clk); n++; end
      end
      repeat (3) begin
         @(negedge clk);
         chk("t4_rvalid_hold", 64'({axil_rvalid, axil_rdata}), 64'({1'b1, 32'hc0debabe}));
      end
      @(posedge clk); #1;
      axil_rready = 1'b1;
      wait_done("t4b");

      // LB handshakes without a request are ignored
      spur = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("spurious_idle", 64'({wen, ren, axil_bvalid, axil_rvalid}), 64'd0);

      // reset during a stalled write aborts it without a response
      wdelay = -1;
      exp_g.push_back(1);
      fork
         send_aw(16'h0020);
         send_w(32'h11111111, 4'hf);
      join
      begin
         int n = 0;
         while (!wen && n < 20) begin @(negedge clk); n++; end
         chk("abort_wen_seen", 64'(wen), 64'd1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_outputs", 64'({wen, ren, axil_bvalid, axil_rvalid}), 64'd0);
      exp_g.delete(); exp_lbw.delete(); exp_b.delete(); exp_r.delete();
      wdelay = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_resp", 64'({wen, axil_bvalid}), 64'd0);

      // 5: simultaneous write and read, twice: W,R then W,R again
      for (int k = 0; k < 2; k++) begin
         logic [15:0] wa, ra;
         logic [31:0] wd;
         wa = 16'h0030 + 16'(k * 8);
         ra = 16'h0034 + 16'(k * 8);
         wd = 32'h5a5a0000 + 32'(k);
         rdata_val = 32'h12340000 + 32'(k);
         expect_wr(wa, wd, 4'hf);
         expect_rd(2'b00, rdata_val);
         fork
            send_aw(wa);
            send_w(wd, 4'hf);
            send_ar(ra);
         join
         wait_done("t5");
      end

`ifdef LB_TIMEOUT_EN
      // 6: LB never answers a read, then a write; both time out with SLVERR
      rdelay = -1;
      expect_rd(2'b10, 32'h0);
      send_ar(16'h0018);
      wait_done("t6_read");
      chk("t6_ren_cycles", 64'(ren_len_last), 64'(TO));
      wdelay = -1;
      exp_g.push_back(1);
      exp_b.push_back(2'b10);
      fork
         send_aw(16'h0040);
         send_w(32'h77777777, 4'hf);
      join
      wait_done("t6_write");
      wdelay = 0;
      rdelay = 1;
      rdata_val = 32'h600dcafe;
      expect_rd(2'b00, 32'h600dcafe);
      send_ar(16'h001c);
      wait_done("t6_next");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500000");
      $fatal(1);
   end

endmodule
